// File: rtl/tpu_result_drainer.sv
// Drains consecutive Output Buffer rows and serializes them into valid/ready stream beats.
// Optional stall-cycle counter enabled by defining DRAIN_PERF_CNT_EN.
module tpu_result_drainer #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int ADDR_WIDTH           = 10,
  parameter int BEAT_WORDS           = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_in,
  input  logic [ADDR_WIDTH-1:0]                  base_addr_in,
  input  logic [ADDR_WIDTH:0]                    num_rows_in,
  output logic                                   busy_out,
  output logic                                   done_out,
  output logic [ADDR_WIDTH-1:0]                  ob_rd_addr_out,
  output logic                                   ob_rd_en_out,
  input  logic [DATA_WIDTH_ACCUM-1:0]            ob_rd_data_in [SYSTOLIC_ARRAY_WIDTH],
  output logic [BEAT_WORDS*DATA_WIDTH_ACCUM-1:0] m_tdata_out,
  output logic                                   m_tvalid_out,
  input  logic                                   m_tready_in,
  output logic                                   m_tlast_out
`ifdef DRAIN_PERF_CNT_EN
  ,
  output logic [31:0]                            stall_cycles_out
`endif
);

  localparam int W     = SYSTOLIC_ARRAY_WIDTH;
  localparam int DW    = DATA_WIDTH_ACCUM;
  localparam int NB    = W / BEAT_WORDS;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_SEND, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_num_rows;
  logic [ADDR_WIDTH:0]   r_row_cnt;
  logic [BC_W-1:0]       r_beat_cnt;
  logic [DW-1:0]         r_row [W];

  logic w_accept;
  logic w_fire;
  logic w_last_beat;
  logic w_last_row;

  assign w_accept    = (r_state == S_IDLE) && start_in;
  assign w_fire      = (r_state == S_SEND) && m_tready_in;
  assign w_last_beat = (r_beat_cnt == BC_W'(NB - 1));
  // Row counter is one bit wider than the address so a full 2^ADDR_WIDTH drain terminates.
  assign w_last_row  = (r_row_cnt == r_num_rows - (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_in) w_state_next = (num_rows_in == '0) ? S_DONE : S_READ;
      end
      S_READ:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_SEND;
      S_SEND: begin
        if (w_fire && w_last_beat) w_state_next = w_last_row ? S_DONE : S_READ;
      end
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_num_rows <= '0;
      r_row_cnt  <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept && (num_rows_in != '0)) begin
        r_base     <= base_addr_in;
        r_num_rows <= num_rows_in;
        r_row_cnt  <= '0;
        r_beat_cnt <= '0;
      end
      if (r_state == S_CAPTURE) r_beat_cnt <= '0;
      if (w_fire) begin
        if (!w_last_beat)    r_beat_cnt <= r_beat_cnt + BC_W'(1);
        else if (!w_last_row) r_row_cnt <= r_row_cnt + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (rst)                        r_row[gi] <= '0;
        else if (r_state == S_CAPTURE)  r_row[gi] <= ob_rd_data_in[gi];
      end
    end

    for (genvar gi = 0; gi < BEAT_WORDS; gi++) begin : g_beat
      logic [IDX_W-1:0] w_idx;
      assign w_idx = IDX_W'(r_beat_cnt) * IDX_W'(BEAT_WORDS) + IDX_W'(gi);
      assign m_tdata_out[gi*DW +: DW] = r_row[w_idx];
    end
  endgenerate

  // Address wraps silently modulo the buffer depth.
  assign ob_rd_addr_out = r_base + r_row_cnt[ADDR_WIDTH-1:0];
  assign ob_rd_en_out   = (r_state == S_READ);
  assign busy_out       = (r_state == S_READ) || (r_state == S_CAPTURE) || (r_state == S_SEND);
  assign done_out       = (r_state == S_DONE);
  assign m_tvalid_out   = (r_state == S_SEND);
  assign m_tlast_out    = (r_state == S_SEND) && w_last_beat && w_last_row;

`ifdef DRAIN_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_accept)
      r_stall_cnt <= '0;
    else if ((r_state == S_SEND) && !m_tready_in && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cycles_out = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tpu_result_drainer.sv
// Directed/randomized bench for tpu_result_drainer against a row/beat queue reference model.
module tb_tpu_result_drainer;

  localparam int W  = 16;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;
  localparam int NB = W / BW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_in = 1'b0;
  logic [AW-1:0]       base_addr_in = '0;
  logic [AW:0]         num_rows_in = '0;
  logic                busy_out;
  logic                done_out;
  logic [AW-1:0]       ob_rd_addr_out;
  logic                ob_rd_en_out;
  logic [DW-1:0]       ob_rd_data_in [W];
  logic [BW*DW-1:0]    m_tdata_out;
  logic                m_tvalid_out;
  logic                m_tready_in = 1'b0;
  logic                m_tlast_out;
`ifdef DRAIN_PERF_CNT_EN
  logic [31:0]         stall_cycles_out;
`endif

  tpu_result_drainer #(
    .SYSTOLIC_ARRAY_WIDTH(W),
    .DATA_WIDTH_ACCUM(DW),
    .ADDR_WIDTH(AW),
    .BEAT_WORDS(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .base_addr_in(base_addr_in),
    .num_rows_in(num_rows_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .ob_rd_addr_out(ob_rd_addr_out),
    .ob_rd_en_out(ob_rd_en_out),
    .ob_rd_data_in(ob_rd_data_in),
    .m_tdata_out(m_tdata_out),
    .m_tvalid_out(m_tvalid_out),
    .m_tready_in(m_tready_in),
    .m_tlast_out(m_tlast_out)
`ifdef DRAIN_PERF_CNT_EN
    ,
    .stall_cycles_out(stall_cycles_out)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] salt = '0;
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic logic [31:0] word_of(input logic [AW-1:0] a, input int idx);
    return salt ^ (32'(a) * 32'd16 + 32'(idx));
  endfunction

  // Output Buffer model: row data valid exactly one cycle after a read enable, junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++)
      ob_rd_data_in[i] <= ob_rd_en_out ? word_of(ob_rd_addr_out, i) : $urandom;
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [AW-1:0] base, input int n, input int mode,
                     input bit inject, input bit abort_mid);
    logic [127:0]  exp_beat [$];
    bit            exp_last [$];
    logic [AW-1:0] exp_addr [$];
    logic [127:0]  b;
    logic [AW-1:0] a;
    logic [127:0]  prev_data = '0;
    logic          prev_last = 1'b0;
    bit            prev_stall = 0;
    bit            done_seen = 0;
    bit            aborted = 0;
    bit            rdy;
    int            t0, last_hs, budget;
    int            hs_cnt = 0;
    int            stalls = 0;

    for (int r = 0; r < n; r++) begin
      a = base + AW'(r);
      exp_addr.push_back(a);
      for (int bb = 0; bb < NB; bb++) begin
        b = '0;
        for (int k = 0; k < BW; k++) b[k*DW +: DW] = word_of(a, bb*BW + k);
        exp_beat.push_back(b);
        exp_last.push_back((r == n-1) && (bb == NB-1));
      end
    end

    base_addr_in = base;
    num_rows_in  = (AW+1)'(n);
    start_in     = 1'b1;
    t0           = cyc;
    last_hs      = t0;
    tick();
    start_in     = 1'b0;
    base_addr_in = AW'($urandom);
    num_rows_in  = (AW+1)'($urandom);
    budget       = n * (NB + 2) * 6 + 20;

    for (int c = 0; c < budget; c++) begin
      if (ob_rd_en_out) begin
        if (exp_addr.size() == 0) check("extra_read", 128'(ob_rd_addr_out) | 128'h1_0000, 128'h0);
        else check("rd_addr", 128'(ob_rd_addr_out), 128'(exp_addr.pop_front()));
      end
      if (n > 0 && cyc == t0 + 1) check("rd_latency", 128'(ob_rd_en_out), 128'(1));
      if (n > 0 && cyc == t0 + 3) check("valid_latency", 128'(m_tvalid_out), 128'(1));
      if (prev_stall) begin
        check("hold_valid", 128'(m_tvalid_out), 128'(1));
        check("hold_data", 128'(m_tdata_out), prev_data);
        check("hold_last", 128'(m_tlast_out), 128'(prev_last));
      end
      if (done_out) begin
        check("done_time", 128'(cyc), 128'(last_hs + 1));
        check("busy_at_done", 128'(busy_out), 128'(0));
        done_seen = 1;
        break;
      end
      check("busy", 128'(busy_out), 128'(n > 0));

      start_in = inject && (cyc == t0 + 2);
      if (start_in) begin
        base_addr_in = AW'($urandom);
        num_rows_in  = (AW+1)'(5);
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[c % 4] : 1'($urandom_range(0, 1));
      m_tready_in = rdy;

      if (abort_mid && m_tvalid_out && hs_cnt == NB + 1) begin
        rst      = 1'b1;
        start_in = 1'b0;
        tick();
        check("abort_valid", 128'(m_tvalid_out), 128'(0));
        check("abort_busy", 128'(busy_out), 128'(0));
        check("abort_done", 128'(done_out), 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          check("post_abort_done", 128'(done_out), 128'(0));
          check("post_abort_rd", 128'(ob_rd_en_out), 128'(0));
        end
`ifdef DRAIN_PERF_CNT_EN
        check("abort_stall_clr", 128'(stall_cycles_out), 128'(0));
`endif
        aborted = 1;
        break;
      end

      if (m_tvalid_out && rdy) begin
        if (exp_beat.size() == 0) begin
          check("extra_beat", 128'(1), 128'(0));
        end else begin
          check("beat_data", 128'(m_tdata_out), exp_beat.pop_front());
          check("beat_last", 128'(m_tlast_out), 128'(exp_last.pop_front()));
        end
        last_hs = cyc;
        hs_cnt++;
      end else if (m_tvalid_out) begin
        stalls++;
      end
      prev_stall = m_tvalid_out && !rdy;
      prev_data  = m_tdata_out;
      prev_last  = m_tlast_out;
      tick();
    end
    start_in = 1'b0;

    if (!aborted) begin
      check("done_seen", 128'(done_seen), 128'(1));
      check("beats_left", 128'(exp_beat.size()), 128'(0));
      check("reads_left", 128'(exp_addr.size()), 128'(0));
`ifdef DRAIN_PERF_CNT_EN
      check("stall_cnt", 128'(stall_cycles_out), 128'(stalls));
`endif
      tick();
      check("done_single", 128'(done_out), 128'(0));
      check("idle_busy", 128'(busy_out), 128'(0));
    end
    $display("xfer base=%03h rows=%0d mode=%0d inject=%0d abort=%0d beats=%0d stalls=%0d",
             base, n, mode, inject, abort_mid, hs_cnt, stalls);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 128'(busy_out), 128'(0));
    check("rst_done", 128'(done_out), 128'(0));
    check("rst_rd_en", 128'(ob_rd_en_out), 128'(0));
    check("rst_rd_addr", 128'(ob_rd_addr_out), 128'(0));
    check("rst_tvalid", 128'(m_tvalid_out), 128'(0));
    check("rst_tlast", 128'(m_tlast_out), 128'(0));
    check("rst_tdata", 128'(m_tdata_out), 128'(0));
`ifdef DRAIN_PERF_CNT_EN
    check("rst_stall", 128'(stall_cycles_out), 128'(0));
`endif
    rst = 1'b0;
    tick();

    salt = '0;
    run(10'h010, 2, 0, 0, 0);
    run(10'h010, 2, 1, 0, 0);
    run(AW'($urandom), 0, 0, 0, 0);
    salt = $urandom;
    run(10'h3FF, 3, 2, 0, 0);
    salt = $urandom;
    run(AW'($urandom), 2, 2, 1, 0);
    salt = $urandom;
    run(AW'($urandom), 4, 2, 0, 1);
    run(AW'($urandom), 4, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      salt = $urandom;
      run(AW'($urandom), $urandom_range(1, 6), 2, 0, 0);
    end
    salt = $urandom;
    run(AW'($urandom), 1024, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tpu_result_drainer.md
Name: tpu_result_drainer

Overview:
- Downstream consumer of the TPU core's Output Buffer read port (AXI-master side).
- On a start command it reads a block of result rows (SYSTOLIC_ARRAY_WIDTH int32 words each) from consecutive Output Buffer addresses.
- Serializes each row into fixed-width stream beats with valid/ready backpressure and marks the final beat of the transfer.
- Feeds the system DMA/AXI write path; reports busy/done to the control unit.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 16, words per Output Buffer row (W).
- DATA_WIDTH_ACCUM, 32, bits per word.
- ADDR_WIDTH, 10, Output Buffer address width.
- BEAT_WORDS, 4, words per stream beat; must divide W; beats per row NB = W/BEAT_WORDS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start_in  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr_in  in  ADDR_WIDTH  first Output Buffer row address.
- num_rows_in  in  ADDR_WIDTH+1  rows to drain (0..2^ADDR_WIDTH).
- busy_out  out  1  high from the cycle after an accepted start until done.
- done_out  out  1  one-cycle pulse at transfer completion.
- ob_rd_addr_out  out  ADDR_WIDTH  Output Buffer read address.
- ob_rd_en_out  out  1  Output Buffer read enable.
- ob_rd_data_in  in  DATA_WIDTH_ACCUM x W (unpacked array)  Output Buffer row; valid exactly 1 cycle after ob_rd_en_out.
- m_tdata_out  out  BEAT_WORDS*DATA_WIDTH_ACCUM  stream beat; word k of the beat in bits [k*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM].
- m_tvalid_out  out  1  beat valid.
- m_tready_in  in  1  sink ready.
- m_tlast_out  out  1  high on the final beat of the whole transfer.

Behaviour:
- Reset: state IDLE; busy_out, done_out, ob_rd_en_out, m_tvalid_out, m_tlast_out = 0; ob_rd_addr_out, m_tdata_out, row register, all counters = 0. Reset mid-transfer aborts immediately; there is no done pulse and no further reads.
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: start_in=1 with num_rows_in>0 latches base/num_rows, clears row_cnt and beat_cnt, and moves to READ. start_in=1 with num_rows_in=0 moves to DONE; no reads are issued. start_in while not IDLE is ignored.
- READ (1 cycle): ob_rd_en_out=1; ob_rd_addr_out=(base+row_cnt) mod 2^ADDR_WIDTH, so the address wraps silently. Next state is CAPTURE.
- CAPTURE (1 cycle): registers ob_rd_data_in into the W-word row register, sets beat_cnt=0, and moves to SEND. ob_rd_en_out=0.
- SEND: m_tvalid_out=1; m_tdata_out = row words [beat_cnt*BEAT_WORDS .. +BEAT_WORDS-1].
  - m_tlast_out=1 iff beat_cnt=NB-1 and row_cnt=num_rows-1.
  - A beat transfers on m_tvalid_out & m_tready_in. tdata and tlast are held stable while valid and not ready.
  - On a transfer that is not the row's last beat: beat_cnt++.
  - On the row's last beat with more rows remaining: row_cnt++, go to READ.
  - On the row's last beat of the final row: go to DONE.
- DONE (1 cycle): done_out=1, busy_out=0; next state is IDLE.
- busy_out=1 in READ, CAPTURE, SEND.
- Latency: start accepted at cycle T gives ob_rd_en_out at T+1, first m_tvalid_out at T+3. With m_tready_in held high, each row costs NB+2 cycles. done_out rises the cycle after the final handshake.
- Data is passed bit-exact; no arithmetic on the payload. Counters are sized so that num_rows=2^ADDR_WIDTH completes correctly.

Optional Feature:
- Macro DRAIN_PERF_CNT_EN.
- Defined: adds output stall_cycles_out [31:0]. It counts cycles with m_tvalid_out=1 and m_tready_in=0, saturates at 0xFFFFFFFF, clears to 0 on reset and on an accepted start, and holds its value after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start base=0x010 num_rows=2, tready=1, rows hold words value=addr*16+idx. Required: ob_rd_en at addresses 0x010 and 0x011 only; 8 beats in order, beat0 = words 0x100..0x103 in LSB-first order; tlast only on beat 8; done_out pulses once, one cycle after the last handshake.
- Same setup with tready toggling 1,0,0,1,... Required: no beat lost or duplicated; tdata stable during stalls; with DRAIN_PERF_CNT_EN, stall_cycles_out equals the number of observed stall cycles.
- start with num_rows=0. Required: no ob_rd_en; done_out at T+1; busy_out never asserted.
- base=0x3FF, num_rows=3. Required: read addresses 0x3FF, 0x000, 0x001 (wrap).
- start pulsed while busy. Required: ignored; the transfer count is unchanged.
- rst asserted during SEND of row 1 of 4. Required: next cycle tvalid=0, busy=0, no done pulse; a subsequent start runs a clean transfer.
